servo_pwm_scheduler: RTL and testbench

//  Frame scheduler for the servoz3 PWM datapath. Holds the per-channel pulse-width targets written through the AXI4-Lite slave registers.

---
 rtl/servo_pwm_scheduler.sv | 171 +++++++++++++++++
 tb/tb_servo_pwm_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_scheduler.sv
// Frame scheduler for the servo PWM datapath: holds clamped per-channel targets,
// slew-limits one channel per cycle at frame start, then drives a common PWM frame.
module servo_pwm_scheduler #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned TICK_DIV  = 100,
   parameter int unsigned FRAME_US  = 20000,
   parameter int unsigned MIN_US    = 1000,
   parameter int unsigned MAX_US    = 2000,
   parameter int unsigned CENTER_US = 1500,
   parameter int unsigned SLEW_US   = 10
) (
   input  logic                   s00_axi_aclk,
   input  logic                   s00_axi_aresetn,
   input  logic                   enable,
   input  logic [NUM_CH-1:0]      cmd_we,
   input  logic [15:0]            cmd_data,
   output logic [NUM_CH-1:0]      pwm_out,
   output logic                   frame_start,
   output logic [NUM_CH*16-1:0]   cur_width,
   output logic                   busy
);

   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [15:0]      US_LAST  = 16'(FRAME_US - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
   localparam logic [15:0]      MIN_W    = 16'(MIN_US);
   localparam logic [15:0]      MAX_W    = 16'(MAX_US);
   localparam logic [15:0]      CTR_W    = 16'(CENTER_US);
   localparam logic [15:0]      SLEW_W   = 16'(SLEW_US);

   typedef enum logic [1:0] {IDLE, UPDATE, RUN} state_t;

   state_t              state_q;
   logic [CH_W-1:0]     ch_idx_q;
   logic [DIV_W-1:0]    div_cnt_q;
   logic [15:0]         us_cnt_q;
   logic [NUM_CH-1:0]   pwm_q;
   logic                frame_start_q;
   logic                busy_q;
   logic [15:0]         tgt_q [NUM_CH];
   logic [15:0]         cur_q [NUM_CH];

   logic [15:0]         tgt_wr_d;
   logic [15:0]         sel_cur;
   logic [15:0]         sel_tgt;
   logic [15:0]         cur_upd_d;
   logic [NUM_CH-1:0]   run_pwm_d;

   always_comb begin
      if (cmd_data < MIN_W)
         tgt_wr_d = MIN_W;
      else if (cmd_data > MAX_W)
         tgt_wr_d = MAX_W;
      else
         tgt_wr_d = cmd_data;
   end

   // Compare before stepping so the 16-bit add/sub can never wrap.
   always_comb begin
      sel_cur   = cur_q[ch_idx_q];
      sel_tgt   = tgt_q[ch_idx_q];
      cur_upd_d = sel_cur;
      if (sel_tgt > sel_cur) begin
         if ((SLEW_US == 0) || ((sel_tgt - sel_cur) <= SLEW_W))
            cur_upd_d = sel_tgt;
         else
            cur_upd_d = sel_cur + SLEW_W;
      end else if (sel_tgt < sel_cur) begin
         if ((SLEW_US == 0) || ((sel_cur - sel_tgt) <= SLEW_W))
            cur_upd_d = sel_tgt;
         else
            cur_upd_d = sel_cur - SLEW_W;
      end
   end

   always_comb begin
      run_pwm_d = '0;
      for (int unsigned k = 0; k < NUM_CH; k++)
         run_pwm_d[k] = (us_cnt_q < cur_q[k]);
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state_q       <= IDLE;
         ch_idx_q      <= '0;
         div_cnt_q     <= '0;
         us_cnt_q      <= '0;
         pwm_q         <= '0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            tgt_q[k] <= CTR_W;
            cur_q[k] <= CTR_W;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_CH; k++)
            if (cmd_we[k]) tgt_q[k] <= tgt_wr_d;
         frame_start_q <= 1'b0;

         unique case (state_q)
            IDLE: begin
               pwm_q     <= '0;
               div_cnt_q <= '0;
               us_cnt_q  <= '0;
               ch_idx_q  <= '0;
               if (enable) begin
                  state_q <= UPDATE;
                  busy_q  <= 1'b1;
               end
            end
            UPDATE: begin
               pwm_q <= '0;
               if (!enable) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  ch_idx_q <= '0;
               end else begin
                  cur_q[ch_idx_q] <= cur_upd_d;
                  if (ch_idx_q == CH_LAST) begin
                     state_q       <= RUN;
                     ch_idx_q      <= '0;
                     div_cnt_q     <= '0;
                     us_cnt_q      <= '0;
                     frame_start_q <= 1'b1;
                  end else begin
                     ch_idx_q <= ch_idx_q + 1'b1;
                  end
               end
            end
            RUN: begin
               if (!enable) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  pwm_q     <= '0;
                  div_cnt_q <= '0;
                  us_cnt_q  <= '0;
               end else begin
                  pwm_q <= run_pwm_d;
                  if (div_cnt_q == DIV_LAST) begin
                     div_cnt_q <= '0;
                     if (us_cnt_q == US_LAST) begin
                        us_cnt_q <= '0;
                        ch_idx_q <= '0;
                        state_q  <= UPDATE;
                     end else begin
                        us_cnt_q <= us_cnt_q + 16'd1;
                     end
                  end else begin
                     div_cnt_q <= div_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      cur_width = '0;
      for (int unsigned k = 0; k < NUM_CH; k++)
         cur_width[16*k +: 16] = cur_q[k];
   end

   assign pwm_out     = pwm_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Directed bench for servo_pwm_scheduler with small frame parameters; second
// instance built with an unlimited slew rate.
module tb_servo_pwm_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable, en0;
   logic [3:0]  cmd_we, we0;
   logic [15:0] cmd_data, data0;
   logic [3:0]  pwm_out, pwm0;
   logic        frame_start, fs0;
   logic [63:0] cur_width, cur0;
   logic        busy, busy0;

   int checks = 0;
   int errors = 0;

   servo_pwm_scheduler #(
      .NUM_CH(4), .TICK_DIV(2), .FRAME_US(50), .MIN_US(10),
      .MAX_US(40), .CENTER_US(25), .SLEW_US(4)
   ) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(enable),
      .cmd_we(cmd_we), .cmd_data(cmd_data), .pwm_out(pwm_out),
      .frame_start(frame_start), .cur_width(cur_width), .busy(busy)
   );

   servo_pwm_scheduler #(
      .NUM_CH(4), .TICK_DIV(2), .FRAME_US(50), .MIN_US(10),
      .MAX_US(40), .CENTER_US(25), .SLEW_US(0)
   ) dut0 (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(en0),
      .cmd_we(we0), .cmd_data(data0), .pwm_out(pwm0),
      .frame_start(fs0), .cur_width(cur0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  we;
      logic [15:0] data;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [16];

   function automatic logic [63:0] cw(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns number of posedges until frame_start is seen (sampled #1 after edge).
   task automatic wait_fs(input bit sel, input int maxc, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      while (!found && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
         if ((sel ? fs0 : frame_start) === 1'b1) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL fs_timeout: got no frame_start within %0d cycles, expected one", maxc);
      end
   endtask

   initial begin
      int n;
      int hi [4];
      int fsn;

      vecs[0]  = '{4'b0001, 16'd40,     cw(29, 25, 25, 25)};
      vecs[1]  = '{4'b0000, 16'd0,      cw(33, 25, 25, 25)};
      vecs[2]  = '{4'b0000, 16'd0,      cw(37, 25, 25, 25)};
      vecs[3]  = '{4'b0000, 16'd0,      cw(40, 25, 25, 25)};
      vecs[4]  = '{4'b0000, 16'd0,      cw(40, 25, 25, 25)};
      vecs[5]  = '{4'b0010, 16'd5,      cw(40, 21, 25, 25)};
      vecs[6]  = '{4'b0100, 16'hFFFF,   cw(40, 17, 29, 25)};
      vecs[7]  = '{4'b0000, 16'd0,      cw(40, 13, 33, 25)};
      vecs[8]  = '{4'b0000, 16'd0,      cw(40, 10, 37, 25)};
      vecs[9]  = '{4'b0000, 16'd0,      cw(40, 10, 40, 25)};
      vecs[10] = '{4'b1111, 16'd30,     cw(36, 14, 36, 29)};
      vecs[11] = '{4'b1000, 16'd10,     cw(32, 18, 32, 25)};
      vecs[12] = '{4'b0000, 16'd0,      cw(30, 22, 30, 21)};
      vecs[13] = '{4'b0000, 16'd0,      cw(30, 26, 30, 17)};
      vecs[14] = '{4'b0010, 16'd41,     cw(30, 30, 30, 13)};
      vecs[15] = '{4'b0000, 16'd0,      cw(30, 34, 30, 10)};

      rst_n = 1'b0; enable = 1'b0; cmd_we = '0; cmd_data = '0;
      en0 = 1'b0; we0 = '0; data0 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cur", cur_width, cw(25, 25, 25, 25));
      check("rst_pwm", {60'd0, pwm_out}, 64'd0);
      check("rst_busy_fs", {62'd0, busy, frame_start}, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", {63'd0, busy}, 64'd0);

      // Startup latency, pulse width and frame period.
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("busy_after_en", {63'd0, busy}, 64'd1);
      wait_fs(1'b0, 200, n);
      check("fs_latency", 64'(n), 64'd4);
      for (int k = 0; k < 4; k++) hi[k] = 0;
      fsn = 0;
      for (int c = 0; c < 104; c++) begin
         for (int k = 0; k < 4; k++) hi[k] += int'(pwm_out[k]);
         fsn += int'(frame_start);
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 4; k++) check($sformatf("pwm_high_ch%0d", k), 64'(hi[k]), 64'd50);
      check("fs_count_in_frame", 64'(fsn), 64'd1);
      check("fs_period_104", {63'd0, frame_start}, 64'd1);

      // Per-frame slew/clamp vectors: write in RUN, check after next UPDATE.
      for (int i = 0; i < 16; i++) begin
         cmd_we = vecs[i].we;
         cmd_data = vecs[i].data;
         @(posedge clk);
         #1;
         cmd_we = '0;
         wait_fs(1'b0, 300, n);
         check($sformatf("vec%0d_cur", i), cur_width, vecs[i].exp);
      end

      // Drop enable mid-RUN, then resume from preserved widths.
      repeat (10) @(posedge clk);
      #1;
      check("pwm_all_high", {60'd0, pwm_out}, 64'hF);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("dis_pwm", {60'd0, pwm_out}, 64'd0);
      check("dis_busy", {63'd0, busy}, 64'd0);
      check("dis_cur_kept", cur_width, cw(30, 34, 30, 10));
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("reen_busy", {63'd0, busy}, 64'd1);
      wait_fs(1'b0, 200, n);
      check("reen_latency", 64'(n), 64'd4);
      check("reen_cur", cur_width, cw(30, 38, 30, 10));

      // Write ch2 during its own UPDATE slot: old target used this frame.
      repeat (102) @(posedge clk);
      #1;
      cmd_we = 4'b0100;
      cmd_data = 16'd40;
      @(posedge clk);
      #1;
      cmd_we = '0;
      wait_fs(1'b0, 50, n);
      check("upd_write_same_frame", cur_width, cw(30, 40, 30, 10));
      wait_fs(1'b0, 300, n);
      check("upd_write_next_frame", cur_width, cw(30, 40, 34, 10));

      // Reset in the middle of UPDATE.
      repeat (101) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("upd_rst_cur", cur_width, cw(25, 25, 25, 25));
      check("upd_rst_pwm_busy", {59'd0, pwm_out, busy}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      wait_fs(1'b0, 200, n);
      check("post_rst_latency", 64'(n), 64'd4);
      check("post_rst_cur", cur_width, cw(25, 25, 25, 25));

      // Unlimited slew build: targets applied in one UPDATE.
      we0 = 4'b0001;
      data0 = 16'd40;
      @(posedge clk);
      #1;
      we0 = 4'b0010;
      data0 = 16'd3;
      @(posedge clk);
      #1;
      we0 = '0;
      en0 = 1'b1;
      @(posedge clk);
      #1;
      wait_fs(1'b1, 200, n);
      check("slew0_cur", cur0, cw(40, 10, 25, 25));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
